// File: rtl/note_sequencer_if.sv
// Command handshake, pitch-table and audio signals of the note sequencer.
// master = melody source / pitch table side, slave = the sequencer.
interface note_sequencer_if;
  logic       note_valid;
  logic       note_ready;
  logic [3:0] note_code;
  logic       note_high;
  logic [3:0] note_len;
  logic [3:0] db_addr;
  logic       db_high;
  logic [7:0] db_entry;
  logic       tone_out;
  logic       busy;
  logic       note_done;

  modport master (
    output note_valid, note_code, note_high, note_len, db_entry,
    input  note_ready, db_addr, db_high, tone_out, busy, note_done
  );

  modport slave (
    input  note_valid, note_code, note_high, note_len, db_entry,
    output note_ready, db_addr, db_high, tone_out, busy, note_done
  );
endinterface

// File: rtl/note_sequencer.sv
// Note-playback controller: looks up a half-period in the pitch table and plays a square wave
// for (note_len+1) beats. Define NOTE_GAP_EN to append GAP_TICKS silent cycles to every note.
module note_sequencer #(
  parameter int unsigned PRESCALE   = 16,
  parameter int unsigned BEAT_TICKS = 4096,
  parameter int unsigned GAP_TICKS  = 256
) (
  input logic             clk,
  input logic             rst,
  note_sequencer_if.slave bus
);

  localparam int unsigned PresW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int unsigned BeatW = (BEAT_TICKS > 1) ? $clog2(BEAT_TICKS) : 1;
  localparam logic [PresW-1:0] PresMax = PresW'(PRESCALE - 1);
  localparam logic [BeatW-1:0] BeatMax = BeatW'(BEAT_TICKS - 1);

`ifdef NOTE_GAP_EN
  localparam int unsigned GapW = (GAP_TICKS > 1) ? $clog2(GAP_TICKS) : 1;
  localparam logic [GapW-1:0] GapMax = GapW'(GAP_TICKS - 1);

  typedef enum logic [1:0] {StIdle, StLoad, StPlay, StGap} state_e;
`else
  typedef enum logic [1:0] {StIdle, StLoad, StPlay} state_e;
`endif

  state_e           state_q, state_d;
  logic             tone_q, tone_d;
  logic             done_q, done_d;
  logic [3:0]       addr_q, addr_d;
  logic             high_q, high_d;
  logic [7:0]       half_q, half_d;
  logic             rest_q, rest_d;
  logic [PresW-1:0] presc_q, presc_d;
  logic [7:0]       div_q, div_d;
  logic [BeatW-1:0] beat_q, beat_d;
  logic [3:0]       beats_q, beats_d;
`ifdef NOTE_GAP_EN
  logic [GapW-1:0]  gap_q, gap_d;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      tone_q  <= 1'b0;
      done_q  <= 1'b0;
      addr_q  <= 4'd0;
      high_q  <= 1'b0;
      half_q  <= 8'd0;
      rest_q  <= 1'b0;
      presc_q <= '0;
      div_q   <= 8'd0;
      beat_q  <= '0;
      beats_q <= 4'd0;
`ifdef NOTE_GAP_EN
      gap_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      tone_q  <= tone_d;
      done_q  <= done_d;
      addr_q  <= addr_d;
      high_q  <= high_d;
      half_q  <= half_d;
      rest_q  <= rest_d;
      presc_q <= presc_d;
      div_q   <= div_d;
      beat_q  <= beat_d;
      beats_q <= beats_d;
`ifdef NOTE_GAP_EN
      gap_q   <= gap_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    tone_d  = tone_q;
    done_d  = 1'b0;
    addr_d  = addr_q;
    high_d  = high_q;
    half_d  = half_q;
    rest_d  = rest_q;
    presc_d = presc_q;
    div_d   = div_q;
    beat_d  = beat_q;
    beats_d = beats_q;
`ifdef NOTE_GAP_EN
    gap_d   = gap_q;
`endif

    unique case (state_q)
      StIdle: begin
        if (bus.note_valid) begin
          // Codes 14 and 15 share the rest entry at address 13.
          addr_d  = (bus.note_code >= 4'd13) ? 4'd13 : bus.note_code;
          high_d  = bus.note_high;
          beats_d = bus.note_len;
          state_d = StLoad;
        end
      end

      StLoad: begin
        half_d  = bus.db_entry;
        rest_d  = (bus.db_entry == 8'd0);
        presc_d = '0;
        div_d   = 8'd0;
        beat_d  = '0;
        tone_d  = 1'b0;
        state_d = StPlay;
      end

      StPlay: begin
        if (presc_q == PresMax) begin
          presc_d = '0;
          if (div_q == half_q - 8'd1) begin
            div_d  = 8'd0;
            tone_d = rest_q ? 1'b0 : ~tone_q;
          end else begin
            div_d = div_q + 8'd1;
          end
        end else begin
          presc_d = presc_q + PresW'(1);
        end

        if (beat_q == BeatMax) begin
          beat_d = '0;
          if (beats_q == 4'd0) begin
            // Note end overrides a toggle landing on the same edge.
            tone_d = 1'b0;
`ifdef NOTE_GAP_EN
            gap_d   = '0;
            state_d = StGap;
`else
            done_d  = 1'b1;
            state_d = StIdle;
`endif
          end else begin
            beats_d = beats_q - 4'd1;
          end
        end else begin
          beat_d = beat_q + BeatW'(1);
        end
      end

`ifdef NOTE_GAP_EN
      StGap: begin
        tone_d = 1'b0;
        if (gap_q == GapMax) begin
          gap_d   = '0;
          done_d  = 1'b1;
          state_d = StIdle;
        end else begin
          gap_d = gap_q + GapW'(1);
        end
      end
`endif

      default: state_d = StIdle;
    endcase
  end

  assign bus.note_ready = (state_q == StIdle);
  assign bus.busy       = (state_q != StIdle);
  assign bus.tone_out   = tone_q;
  assign bus.note_done  = done_q;
  assign bus.db_addr    = addr_q;
  assign bus.db_high    = high_q;

endmodule
